// File: rtl/r2sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage (DIF). Sequences an external
// N-deep free-running delay line: sums leave in phase B, differences drain afterwards.
module r2sdf_butterfly #(
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int SCALE = 1,
    localparam int IW   = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic [2*W-1:0]      dly_in,
    input  logic [2*W-1:0]      dly_out,
    output logic                out_valid,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_diff,
    output logic [IW-1:0]       out_idx,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t      r_state;
    logic [IW:0] r_cnt;
    logic        r_pend;

    logic signed [W-1:0] w_a_re, w_a_im;
    logic signed [W:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic                w_phase_b, w_drain0;

    function automatic logic signed [W-1:0] scale_fn(input logic signed [W:0] v);
        if (SCALE == 1) return v[W:1];
        else            return v[W-1:0];
    endfunction

    assign w_a_re    = dly_out[2*W-1:W];
    assign w_a_im    = dly_out[W-1:0];
    assign w_sum_re  = {w_a_re[W-1], w_a_re} + {in_re[W-1], in_re};
    assign w_sum_im  = {w_a_im[W-1], w_a_im} + {in_im[W-1], in_im};
    assign w_dif_re  = {w_a_re[W-1], w_a_re} - {in_re[W-1], in_re};
    assign w_dif_im  = {w_a_im[W-1], w_a_im} - {in_im[W-1], in_im};
    assign w_phase_b = r_cnt[IW];

    // A frame boundary with no new input and differences outstanding is the first drain slot.
    assign w_drain0  = (r_state == S_RUN) && (r_cnt == '0) && !in_valid && r_pend;
    assign in_ready  = (r_state != S_DRAIN) && !w_drain0;

    always_comb begin
        dly_in = {in_re, in_im};
        if (r_state == S_DRAIN || w_drain0)
            dly_in = '0;
        else if (r_state == S_RUN && w_phase_b)
            dly_in = {scale_fn(w_dif_re), scale_fn(w_dif_im)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_diff  <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_RUN;
                        r_cnt   <= (IW+1)'(1);
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        if (!w_phase_b) begin
                            if (r_pend) begin
                                out_valid <= 1'b1;
                                out_re    <= w_a_re;
                                out_im    <= w_a_im;
                                out_diff  <= 1'b1;
                                out_idx   <= r_cnt[IW-1:0];
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_re    <= scale_fn(w_sum_re);
                            out_im    <= scale_fn(w_sum_im);
                            out_diff  <= 1'b0;
                            out_idx   <= r_cnt[IW-1:0];
                        end
                        if (r_cnt == (IW+1)'(2*N-1)) begin
                            r_cnt  <= '0;
                            r_pend <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_cnt == '0) begin
                        if (r_pend) begin
                            out_valid <= 1'b1;
                            out_re    <= w_a_re;
                            out_im    <= w_a_im;
                            out_diff  <= 1'b1;
                            out_idx   <= '0;
                            r_state   <= S_DRAIN;
                            r_cnt     <= (IW+1)'(1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        // Mid-frame gap: the delay line holds a torn frame, so forget it.
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    out_valid <= 1'b1;
                    out_re    <= w_a_re;
                    out_im    <= w_a_im;
                    out_diff  <= 1'b1;
                    out_idx   <= r_cnt[IW-1:0];
                    if (r_cnt == (IW+1)'(N-1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r2sdf_butterfly.sv
// Scoreboard bench for r2sdf_butterfly: two instances (scaled and wrapping), each
// with its own free-running 8-deep delay line.
module tb_r2sdf_butterfly;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               a_vld = 1'b0, a_rdy, a_ov, a_odiff, a_err;
    logic signed [15:0] a_re = '0, a_im = '0, a_ore, a_oim;
    logic [31:0]        a_dly_in, a_dly_out;
    logic [2:0]         a_oidx;
    logic [31:0]        a_dl [8];

    logic               b_vld = 1'b0, b_rdy, b_ov, b_odiff, b_err;
    logic signed [15:0] b_re = '0, b_im = '0, b_ore, b_oim;
    logic [31:0]        b_dly_in, b_dly_out;
    logic [2:0]         b_oidx;
    logic [31:0]        b_dl [8];

    r2sdf_butterfly #(.W(16), .N(8), .SCALE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_vld), .in_ready(a_rdy),
        .in_re(a_re), .in_im(a_im), .dly_in(a_dly_in), .dly_out(a_dly_out),
        .out_valid(a_ov), .out_re(a_ore), .out_im(a_oim), .out_diff(a_odiff),
        .out_idx(a_oidx), .err(a_err));

    r2sdf_butterfly #(.W(16), .N(8), .SCALE(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_vld), .in_ready(b_rdy),
        .in_re(b_re), .in_im(b_im), .dly_in(b_dly_in), .dly_out(b_dly_out),
        .out_valid(b_ov), .out_re(b_ore), .out_im(b_oim), .out_diff(b_odiff),
        .out_idx(b_oidx), .err(b_err));

    always @(posedge clk) begin
        a_dl[0] <= a_dly_in;
        b_dl[0] <= b_dly_in;
        for (int i = 1; i < 8; i++) begin
            a_dl[i] <= a_dl[i-1];
            b_dl[i] <= b_dl[i-1];
        end
    end
    assign a_dly_out = a_dl[7];
    assign b_dly_out = b_dl[7];

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               diff;
        logic [2:0]         idx;
        int                 cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    logic signed [15:0] xr [16], xi [16];
    logic signed [15:0] esr [8], esi [8], edr [8], edi [8];
    int last_t0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_ov) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL mon_a unexpected output cyc=%0d re=%0d im=%0d diff=%0d idx=%0d",
                         cyc, a_ore, a_oim, a_odiff, a_oidx);
            end else begin
                e = qa.pop_front();
                if (a_ore !== e.re || a_oim !== e.im || a_odiff !== e.diff ||
                    a_oidx !== e.idx || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL mon_a got re=%0d im=%0d diff=%0d idx=%0d cyc=%0d want re=%0d im=%0d diff=%0d idx=%0d cyc=%0d",
                             a_ore, a_oim, a_odiff, a_oidx, cyc, e.re, e.im, e.diff, e.idx, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_ov) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL mon_b unexpected output cyc=%0d re=%0d im=%0d diff=%0d idx=%0d",
                         cyc, b_ore, b_oim, b_odiff, b_oidx);
            end else begin
                e = qb.pop_front();
                if (b_ore !== e.re || b_oim !== e.im || b_odiff !== e.diff ||
                    b_oidx !== e.idx || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL mon_b got re=%0d im=%0d diff=%0d idx=%0d cyc=%0d want re=%0d im=%0d diff=%0d idx=%0d cyc=%0d",
                             b_ore, b_oim, b_odiff, b_oidx, cyc, e.re, e.im, e.diff, e.idx, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cyc %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Drives 16 consecutive samples and queues the hand-computed sums/differences.
    task automatic send_frame(input bit to_b, input int ndiff);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                last_t0 = cyc;
                for (int j = 0; j < 8; j++) begin
                    e = '{esr[j], esi[j], 1'b0, 3'(j), cyc + 9 + j};
                    if (to_b) qb.push_back(e); else qa.push_back(e);
                end
                for (int j = 0; j < ndiff; j++) begin
                    e = '{edr[j], edi[j], 1'b1, 3'(j), cyc + 17 + j};
                    if (to_b) qb.push_back(e); else qa.push_back(e);
                end
            end
            if (to_b) begin b_vld = 1'b1; b_re = xr[k]; b_im = xi[k]; end
            else      begin a_vld = 1'b1; a_re = xr[k]; a_im = xi[k]; end
        end
    endtask

    task automatic stop_in();
        @(posedge clk); #1;
        a_vld = 1'b0;
        b_vld = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) begin xr[k] = 16'(k + 1); xi[k] = '0; end
        for (int j = 0; j < 8; j++) begin
            esr[j] = 16'(j + 5); esi[j] = '0; edr[j] = -16'sd4; edi[j] = '0;
        end
    endtask

    task automatic set_imag_ramp();
        for (int k = 0; k < 16; k++) begin xr[k] = '0; xi[k] = 16'(2 * k); end
        for (int j = 0; j < 8; j++) begin
            esr[j] = '0; esi[j] = 16'(2 * j + 8); edr[j] = '0; edi[j] = -16'sd8;
        end
    endtask

    initial begin
        int t;
        // Reset with random inputs
        repeat (3) begin
            @(posedge clk); #1;
            a_vld = 1'($urandom); a_re = 16'($urandom); a_im = 16'($urandom);
            b_vld = 1'($urandom); b_re = 16'($urandom); b_im = 16'($urandom);
        end
        rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_re", a_ore, 0);
        chk("rst_out_im", a_oim, 0);
        chk("rst_out_diff", a_odiff, 0);
        chk("rst_out_idx", a_oidx, 0);
        chk("rst_err", a_err, 0);
        chk("rst_in_ready", a_rdy, 1);
        wait_cyc(3);

        // Single frame, then drain
        set_ramp();
        send_frame(1'b0, 8);
        stop_in();
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("drain_in_ready", a_rdy, 0);
        end
        @(negedge clk);
        chk("post_drain_in_ready", a_rdy, 1);
        wait_cyc(3);

        // Back-to-back frames
        set_ramp();
        send_frame(1'b0, 8);
        set_imag_ramp();
        send_frame(1'b0, 8);
        stop_in();
        wait_cyc(12);

        // Scaling: re a=-3,b=0 ; im a=b=32767
        for (int k = 0; k < 16; k++) begin
            xr[k] = (k < 8) ? -16'sd3 : 16'sd0;
            xi[k] = 16'sd32767;
        end
        for (int j = 0; j < 8; j++) begin
            esr[j] = -16'sd2; esi[j] = 16'sd32767; edr[j] = -16'sd2; edi[j] = '0;
        end
        send_frame(1'b0, 8);
        stop_in();
        wait_cyc(12);
        for (int j = 0; j < 8; j++) begin
            esr[j] = -16'sd3; esi[j] = -16'sd2; edr[j] = -16'sd3; edi[j] = '0;
        end
        send_frame(1'b1, 8);
        stop_in();
        wait_cyc(12);

        // Abort at cnt=5
        chk("err_clean", a_err, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            a_vld = 1'b1; a_re = 16'(100 + k); a_im = 16'(7);
        end
        stop_in();
        @(negedge clk);
        chk("err_in_abort_slot", a_err, 0);
        @(negedge clk);
        chk("err_after_abort", a_err, 1);
        chk("abort_in_ready", a_rdy, 1);
        wait_cyc(2);
        for (int k = 0; k < 16; k++) begin xr[k] = 16'(k); xi[k] = -16'(k); end
        for (int j = 0; j < 8; j++) begin
            esr[j] = 16'(j + 4); esi[j] = -16'(j + 4); edr[j] = -16'sd4; edi[j] = 16'sd4;
        end
        send_frame(1'b0, 8);
        stop_in();
        wait_cyc(12);
        chk("err_sticky", a_err, 1);

        // Reset during drain cycle 3
        set_ramp();
        send_frame(1'b0, 2);
        t = last_t0;
        stop_in();
        while (cyc < t + 19) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", a_ov, 0);
        chk("mid_rst_out_re", a_ore, 0);
        chk("mid_rst_out_im", a_oim, 0);
        chk("mid_rst_out_diff", a_odiff, 0);
        chk("mid_rst_out_idx", a_oidx, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_in_ready", a_rdy, 1);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        set_imag_ramp();
        send_frame(1'b0, 8);
        stop_in();
        wait_cyc(12);

        @(negedge clk);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
